// File: rtl/rgb565_gray_gauss.sv
// rgb565_gray_gauss
// RGB565 pixel stream -> 8-bit luma -> 3x3 Gaussian (1 2 1 / 2 4 2 / 1 2 1)/16.
// Luma takes 3 cycles and the Gaussian takes 3 more. vsync/href/de travel
// through a matching 6-deep delay line so they stay aligned with the data.
// The line buffers are plain RAM with no reset. The row counter masks their
// stale contents, so a reset or a new frame never leaks old pixels.
module rgb565_gray_gauss #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pre_frame_vsync,
  input  logic                  pre_frame_href,
  input  logic                  pre_frame_de,
  input  logic [15:0]           pre_rgb,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_de,
  output logic [DATA_WIDTH-1:0] post_img_gray
);

  localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CW = $clog2(DATA_DEPTH + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(DATA_DEPTH);

  // Weighted 1-2-1 sum of one window row.
  function automatic logic [DATA_WIDTH+1:0] row_sum(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c
  );
    row_sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Luma datapath
  logic [7:0]            r8_s, g8_s, b8_s;
  logic [15:0]           prod_r_r, prod_g_r, prod_b_r, luma_sum_r;
  logic [DATA_WIDTH-1:0] luma_r;

  // Sync delay line: index 2 is aligned with luma_r, index 5 drives the outputs
  logic [2:0] sync_r [0:5];

  // Y-stage control
  logic            y_vs_s, y_hr_s, y_de_s, vs_rise_s, hr_fall_s, col_in_s;
  logic            y_vs_d_r, y_hr_d_r, line_de_r;
  logic [CW-1:0]   col_r;
  logic [AW-1:0]   col_idx_s;
  logic [11:0]     row_r, row_eff_s;
  logic [DATA_WIDTH-1:0] rd1_s, rd2_s, new_mid_s, new_top_s;

  // Line buffers: buf1 holds row r-1, buf2 holds row r-2
  logic [DATA_WIDTH-1:0] line_buf1 [0:DATA_DEPTH-1];
  logic [DATA_WIDTH-1:0] line_buf2 [0:DATA_DEPTH-1];

  // Window [row][col]: row 0 = r-2, 2 = r; col 0 = c-2, 2 = c
  logic [DATA_WIDTH-1:0] win_r [0:2][0:2];
  logic [DATA_WIDTH+1:0] top_sum_r, bot_sum_r;
  logic [DATA_WIDTH+2:0] mid_sum_r;
  logic [11:0]           gauss_sum_s;

  // Expand RGB565 components to 8 bits by replicating their MSBs
  always_comb begin
    r8_s = {pre_rgb[15:11], pre_rgb[15:13]};
    g8_s = {pre_rgb[10:5],  pre_rgb[10:9]};
    b8_s = {pre_rgb[4:0],   pre_rgb[4:2]};
  end

  // Luma pipeline: multiply, add, shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_r   <= 16'd0;
      prod_g_r   <= 16'd0;
      prod_b_r   <= 16'd0;
      luma_sum_r <= 16'd0;
      luma_r     <= '0;
    end else begin
      prod_r_r   <= 16'd77  * {8'd0, r8_s};
      prod_g_r   <= 16'd150 * {8'd0, g8_s};
      prod_b_r   <= 16'd29  * {8'd0, b8_s};
      luma_sum_r <= prod_r_r + prod_g_r + prod_b_r;
      luma_r     <= DATA_WIDTH'(luma_sum_r >> 4'd8);
    end
  end

  // Delay vsync/href/de through six stages alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        sync_r[i] <= 3'b000;
      end
    end else begin
      sync_r[0] <= {pre_frame_vsync, pre_frame_href, pre_frame_de};
      for (int i = 1; i < 6; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Y-stage decode: edges, buffer reads and zero padding of the upper rows
  always_comb begin
    y_vs_s    = sync_r[2][2];
    y_hr_s    = sync_r[2][1];
    y_de_s    = sync_r[2][0] & sync_r[2][1];
    vs_rise_s = y_vs_s & ~y_vs_d_r;
    hr_fall_s = y_hr_d_r & ~y_hr_s;
    col_in_s  = (col_r < COL_MAX);
    col_idx_s = col_r[AW-1:0];
    rd1_s     = line_buf1[col_idx_s];
    rd2_s     = line_buf2[col_idx_s];
    // A pixel arriving with the vsync edge already belongs to row 0
    if (vs_rise_s) begin
      row_eff_s = 12'd0;
    end else begin
      row_eff_s = row_r;
    end
    if ((row_eff_s >= 12'd1) && col_in_s) begin
      new_mid_s = rd1_s;
    end else begin
      new_mid_s = '0;
    end
    if ((row_eff_s >= 12'd2) && col_in_s) begin
      new_top_s = rd2_s;
    end else begin
      new_top_s = '0;
    end
  end

  // Column/row counters and sync edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_vs_d_r  <= 1'b0;
      y_hr_d_r  <= 1'b0;
      line_de_r <= 1'b0;
      col_r     <= '0;
      row_r     <= 12'd0;
    end else begin
      y_vs_d_r <= y_vs_s;
      y_hr_d_r <= y_hr_s;
      if (!y_hr_s) begin
        col_r <= '0;
      end else if (y_de_s && col_in_s) begin
        col_r <= col_r + 1'b1;
      end
      if (vs_rise_s) begin
        row_r <= 12'd0;
      end else if (hr_fall_s && line_de_r && (row_r != 12'hFFF)) begin
        row_r <= row_r + 12'd1;
      end
      if (hr_fall_s) begin
        line_de_r <= 1'b0;
      end else if (y_de_s) begin
        line_de_r <= 1'b1;
      end
    end
  end

  // Line buffer update: row r-1 moves down to r-2, the current luma becomes r-1
  always_ff @(posedge clk) begin
    if (y_de_s && col_in_s) begin
      line_buf2[col_idx_s] <= line_buf1[col_idx_s];
      line_buf1[col_idx_s] <= luma_r;
    end
  end

  // 3x3 window: shift one column per pixel and clear between lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (!y_hr_s) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (y_de_s) begin
      for (int i = 0; i < 3; i++) begin
        win_r[i][0] <= win_r[i][1];
        win_r[i][1] <= win_r[i][2];
      end
      win_r[0][2] <= new_top_s;
      win_r[1][2] <= new_mid_s;
      win_r[2][2] <= luma_r;
    end
  end

  // Row sums; the middle row carries the extra weight of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_sum_r <= '0;
      mid_sum_r <= '0;
      bot_sum_r <= '0;
    end else begin
      top_sum_r <= row_sum(win_r[0][0], win_r[0][1], win_r[0][2]);
      mid_sum_r <= {row_sum(win_r[1][0], win_r[1][1], win_r[1][2]), 1'b0};
      bot_sum_r <= row_sum(win_r[2][0], win_r[2][1], win_r[2][2]);
    end
  end

  // Combine the three row sums into the full kernel sum
  always_comb begin
    gauss_sum_s = {2'b00, top_sum_r} + {1'b0, mid_sum_r} + {2'b00, bot_sum_r};
  end

  // Final divide by 16; the output is forced to 0 when no pixel is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_gray <= '0;
    end else if (sync_r[4][0]) begin
      post_img_gray <= DATA_WIDTH'(gauss_sum_s >> 4'd4);
    end else begin
      post_img_gray <= '0;
    end
  end

  assign post_frame_vsync = sync_r[5][2];
  assign post_frame_href  = sync_r[5][1];
  assign post_frame_de    = sync_r[5][0];

endmodule

// File: tb/tb_rgb565_gray_gauss.sv
// Scoreboard bench for rgb565_gray_gauss. The stimulus side pushes the
// expected outputs, and the monitor pops and compares them on the falling edge.
// The reference model keeps a per-frame image of luma values and evaluates
// the kernel directly over it.
module tb_rgb565_gray_gauss;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pre_v = 1'b0, pre_h = 1'b0, pre_de = 1'b0;
  logic [15:0] pre_rgb = 16'h0000;
  logic        post_v, post_h, post_de;
  logic [7:0]  post_gray;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] sync_q [$];
  int         gray_q [$];
  int         tbl [$];
  bit         use_tbl = 1'b0;
  bit         mon_en = 1'b0;
  bit         end_req = 1'b0;

  // reference model state
  int m_row, m_col;
  bit m_line_de, m_prev_h, m_prev_v;
  int img [0:15][0:31];
  logic [15:0] lut [0:4] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  rgb565_gray_gauss #(.DATA_WIDTH(8), .DATA_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pre_frame_vsync  (pre_v),
    .pre_frame_href   (pre_h),
    .pre_frame_de     (pre_de),
    .pre_rgb          (pre_rgb),
    .post_frame_vsync (post_v),
    .post_frame_href  (post_h),
    .post_frame_de    (post_de),
    .post_img_gray    (post_gray)
  );

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int luma(logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Pixel at (r-i, c-j); out-of-frame, not-yet-seen or beyond-buffer taps are 0
  function automatic int tap(int r, int c, int i, int j);
    int rr, cc;
    rr = r - i;
    cc = c - j;
    if (cc < 0) return 0;
    if (i > 0 && (rr < 0 || cc >= DEPTH)) return 0;
    return img[rr][cc];
  endfunction

  function automatic int exp_gray(int r, int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * tap(r, c, i, j);
    return s / 16;
  endfunction

  // Drive one cycle of input and record what must appear at the output
  task automatic cyc(bit v, bit h, bit de, logic [15:0] rgb);
    int e;
    pre_v = v; pre_h = h; pre_de = de; pre_rgb = rgb;
    if (v && !m_prev_v) m_row = 0;
    else if (!h && m_prev_h && m_line_de) m_row++;
    if (!h && m_prev_h) m_line_de = 1'b0;
    if (!h) m_col = 0;
    sync_q.push_back({v, h, de});
    if (h && de) begin
      img[m_row][m_col] = luma(rgb);
      e = exp_gray(m_row, m_col);
      if (use_tbl) e = tbl.pop_front();
      gray_q.push_back(e);
      m_line_de = 1'b1;
      m_col++;
    end
    m_prev_v = v;
    m_prev_h = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    mon_en = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      pre_v = 1'($urandom); pre_h = 1'($urandom); pre_de = 1'($urandom);
      pre_rgb = 16'($urandom);
      @(posedge clk);
      #1;
    end
    pre_v = 1'b0; pre_h = 1'b0; pre_de = 1'b0; pre_rgb = 16'h0000;
    sync_q.delete();
    gray_q.delete();
    m_row = 0; m_col = 0; m_line_de = 1'b0; m_prev_h = 1'b0; m_prev_v = 1'b0;
    rst_n = 1'b1;
    repeat (6) sync_q.push_back(3'b000);
    mon_en = 1'b1;
  endtask

  // mode: 0 random pixels, 1 white, 2 luma colour list; gap: 0 none, 1 alternate, 2 random
  task automatic frame(int rows, int cols, int gap, int mode);
    logic [15:0] px;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if ((gap == 1 && c > 0) || (gap == 2 && $urandom_range(0, 2) == 0))
          cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
        case (mode)
          1:       px = 16'hFFFF;
          2:       px = lut[c % 5];
          default: px = 16'($urandom);
        endcase
        cyc(1'b0, 1'b1, 1'b1, px);
      end
      repeat (2 + $urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic load_white_tbl();
    int w [12] = '{15, 47, 63, 63, 47, 143, 191, 191, 63, 191, 255, 255};
    tbl.delete();
    foreach (w[k]) tbl.push_back(w[k]);
  endtask

  // Monitor: reset checks, then scoreboard comparison of every output cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vsync", int'(post_v), 0);
      chk("rst_href", int'(post_h), 0);
      chk("rst_de", int'(post_de), 0);
      chk("rst_gray", int'(post_gray), 0);
    end else if (mon_en) begin
      chk("sync_avail", int'(sync_q.size() > 0), 1);
      if (sync_q.size() > 0)
        chk("sync", int'({post_v, post_h, post_de}), int'(sync_q.pop_front()));
      if (post_de) begin
        chk("gray_avail", int'(gray_q.size() > 0), 1);
        if (gray_q.size() > 0) chk("gray", int'(post_gray), gray_q.pop_front());
      end else begin
        chk("gray_idle", int'(post_gray), 0);
      end
    end
    if (end_req) chk("gray_drained", gray_q.size(), 0);
  end

  initial begin
    do_reset(8);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, 16'h0000);

    // luma colours on a single row and on two rows
    frame(1, 5, 0, 2);
    frame(2, 5, 0, 2);

    // latency and sync shape: pulse with vsync/href rising together
    cyc(1'b1, 1'b1, 1'b1, 16'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0000);

    // constant white frame, gapped version, then a fresh identical frame
    load_white_tbl(); use_tbl = 1'b1; frame(3, 4, 0, 1);
    load_white_tbl(); frame(3, 4, 1, 1);
    load_white_tbl(); frame(3, 4, 0, 1);
    use_tbl = 1'b0;

    // random frames, some lines wider than the line buffer
    repeat (6) frame($urandom_range(1, 5), $urandom_range(1, 20), 2, 0);

    // reset in the middle of a line, then a clean frame
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
    do_reset(3);
    frame(3, 6, 2, 0);

    repeat (10) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    end_req = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
